// File: rtl/fp_mant_norm_round_pkg.sv
// fp_pkg: shared widths, result packing and flag positions for the FP post-adder stage.
package fp_pkg;
    localparam int MANT_W  = 24;
    localparam int EXP_W   = 8;
    localparam int EXP_MAX = 255;
    localparam int BIAS    = 127;
    localparam int FLAG_OV = 2;
    localparam int FLAG_UF = 1;
    localparam int FLAG_NX = 0;
    typedef logic [2:0] grs_t;
    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MANT_W-2:0] frac;
    } fp32_t;
endpackage

// File: rtl/fp_mant_norm_round_if.sv
// fp_mant_norm_round_if: input and output valid/ready channels of the normalise/round stage.
interface fp_mant_norm_round_if;
    import fp_pkg::*;
    logic              in_valid;
    logic              in_ready;
    logic [MANT_W:0]   in_sum;
    logic [EXP_W-1:0]  in_exp;
    logic              in_sign;
    grs_t              in_grs;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_result;
    logic [2:0]        out_flags;
    modport master (
        output in_valid, in_sum, in_exp, in_sign, in_grs, out_ready,
        input  in_ready, out_valid, out_result, out_flags
    );
    modport slave (
        input  in_valid, in_sum, in_exp, in_sign, in_grs, out_ready,
        output in_ready, out_valid, out_result, out_flags
    );
endinterface

// File: rtl/fp_mant_norm_round_lzc24.sv
// lzc24: combinational leading-zero count of a 24-bit value, 24 when all zero.
module lzc24 (
    input  logic [23:0] i_val,
    output logic [4:0]  o_lz
);
    always_comb begin
        o_lz = 5'd24;
        for (int i = 0; i < 24; i++) o_lz = i_val[i] ? 5'(23 - i) : o_lz;
    end
endmodule

// File: rtl/fp_mant_norm_round.sv
// fp_mant_norm_round: normalise, round-to-nearest-even and pack the FP add/sub mantissa sum.
// Pipeline: S1 capture + LZC, S2 normalise, S3 round + pack into the output register.
module fp_mant_norm_round
    import fp_pkg::*;
(
    input logic                 clk,
    input logic                 rst_n,
    fp_mant_norm_round_if.slave bus
);
    logic                    w_s1_adv, w_s2_adv, w_s3_adv;
    logic [4:0]              w_lz;
    logic                    r_s1_v, r_s1_sign, r_s1_zero;
    logic [MANT_W:0]         r_s1_sum;
    logic [EXP_W-1:0]        r_s1_exp;
    grs_t                    r_s1_grs;
    logic [4:0]              r_s1_lz;
    logic                    r_s2_v, r_s2_hid, r_s2_g, r_s2_r, r_s2_s, r_s2_sign, r_s2_zero;
    logic [MANT_W-2:0]       r_s2_frac;
    logic signed [9:0]       r_s2_exp;
    logic                    r_s3_v;
    fp32_t                   r_res;
    logic [2:0]              r_flags;
    logic [4:0]              w_sh;
    logic [MANT_W+1:0]       w_left;
    logic                    w_carry;
    logic signed [9:0]       w_n_exp;
    logic                    w_up, w_rc, w_ov, w_uf, w_nx;
    logic [MANT_W-2:0]       w_frac;
    logic signed [9:0]       w_exp;
    fp32_t                   w_res;
    logic [2:0]              w_flags;

    assign w_s3_adv       = !r_s3_v || bus.out_ready;
    assign w_s2_adv       = !r_s2_v || w_s3_adv;
    assign w_s1_adv       = !r_s1_v || w_s2_adv;
    assign bus.in_ready   = w_s1_adv;
    assign bus.out_valid  = r_s3_v;
    assign bus.out_result = r_res;
    assign bus.out_flags  = r_flags;
    assign w_carry        = r_s1_sum[MANT_W];

    lzc24 u_lzc (.i_val(bus.in_sum[MANT_W-1:0]), .o_lz(w_lz));

    // With sum[23:0]==0 the leading one lives in g/r, so extend the shift past 24.
    always_comb begin
        w_sh    = (r_s1_lz == 5'd24) ? (r_s1_grs[2] ? 5'd24 : r_s1_grs[1] ? 5'd25 : 5'd26) : r_s1_lz;
        w_left  = {r_s1_sum[MANT_W-1:0], r_s1_grs[2:1]} << w_sh;
        w_n_exp = w_carry ? $signed({2'b00, r_s1_exp}) + 10'sd1
                          : $signed({2'b00, r_s1_exp}) - $signed({5'b00000, w_sh});
    end

    // A missing hidden bit means only sticky survived: too small to represent, so underflow.
    always_comb begin
        w_up          = r_s2_g & (r_s2_r | r_s2_s | r_s2_frac[0]);
        {w_rc, w_frac} = {1'b0, r_s2_frac} + 24'(w_up);
        w_exp         = r_s2_exp + $signed({9'b0, w_rc});
        w_nx          = r_s2_g | r_s2_r | r_s2_s;
        w_ov          = w_exp >= $signed(10'(EXP_MAX));
        w_uf          = (w_exp <= 10'sd0) || !r_s2_hid;
        w_res.sign    = r_s2_sign & !r_s2_zero;
        w_res.exp     = (r_s2_zero || w_uf) ? '0 : w_ov ? 8'(EXP_MAX) : w_exp[EXP_W-1:0];
        w_res.frac    = (r_s2_zero || w_uf || w_ov) ? '0 : w_frac;
        w_flags          = '0;
        w_flags[FLAG_OV] = !r_s2_zero & w_ov;
        w_flags[FLAG_UF] = !r_s2_zero & w_uf & !w_ov;
        w_flags[FLAG_NX] = !r_s2_zero & (w_nx | w_ov);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_v    <= 1'b0;
            r_s1_sum  <= '0;
            r_s1_exp  <= '0;
            r_s1_sign <= 1'b0;
            r_s1_grs  <= '0;
            r_s1_lz   <= '0;
            r_s1_zero <= 1'b0;
            r_s2_v    <= 1'b0;
            r_s2_hid  <= 1'b0;
            r_s2_frac <= '0;
            r_s2_g    <= 1'b0;
            r_s2_r    <= 1'b0;
            r_s2_s    <= 1'b0;
            r_s2_exp  <= '0;
            r_s2_sign <= 1'b0;
            r_s2_zero <= 1'b0;
            r_s3_v    <= 1'b0;
            r_res     <= '0;
            r_flags   <= '0;
        end else begin
            if (w_s1_adv) begin
                r_s1_v <= bus.in_valid;
                if (bus.in_valid) begin
                    r_s1_sum  <= bus.in_sum;
                    r_s1_exp  <= bus.in_exp;
                    r_s1_sign <= bus.in_sign;
                    r_s1_grs  <= bus.in_grs;
                    r_s1_lz   <= w_lz;
                    r_s1_zero <= (bus.in_sum == '0) && (bus.in_grs == '0);
                end
            end
            if (w_s2_adv) begin
                r_s2_v <= r_s1_v;
                if (r_s1_v) begin
                    r_s2_hid  <= w_carry | w_left[MANT_W+1];
                    r_s2_frac <= w_carry ? r_s1_sum[MANT_W-1:1] : w_left[MANT_W:2];
                    r_s2_g    <= w_carry ? r_s1_sum[0] : w_left[1];
                    r_s2_r    <= w_carry ? r_s1_grs[2] : w_left[0];
                    r_s2_s    <= w_carry ? |r_s1_grs[1:0] : r_s1_grs[0];
                    r_s2_exp  <= w_n_exp;
                    r_s2_sign <= r_s1_sign;
                    r_s2_zero <= r_s1_zero;
                end
            end
            if (w_s3_adv) begin
                r_s3_v <= r_s2_v;
                if (r_s2_v) begin
                    r_res   <= w_res;
                    r_flags <= w_flags;
                end
            end
        end
    end
endmodule
